// File: rtl/ex_div_unit.sv
// Iterative RV32M divider for the execute stage: DIV/DIVU/REM/REMU by restoring division,
// one quotient bit per cycle, with single-cycle completion for divide-by-zero and signed overflow.
module ex_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        stall,
    output logic        valid,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_next;
    logic [5:0]  count;
    logic [31:0] rem_q, quo_q, dvs_mag;
    logic        op_rem, neg_quo, neg_rem;

    logic        signed_op, div_zero, overflow, fast, accept;
    logic [31:0] fast_result, dvd_abs, dvs_abs;
    logic [32:0] trial;
    logic [31:0] step_rem, step_quo, final_result;

    assign signed_op = ~op[0];
    assign div_zero  = (divisor == 32'd0);
    assign overflow  = signed_op && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
    assign fast      = div_zero | overflow;
    assign accept    = start & ~flush;

    assign dvd_abs = (signed_op && dividend[31]) ? (32'd0 - dividend) : dividend;
    assign dvs_abs = (signed_op && divisor[31])  ? (32'd0 - divisor)  : divisor;

    // Divide-by-zero returns all-ones / the raw dividend; overflow returns INT_MIN / zero.
    always_comb begin
        fast_result = 32'd0;
        if (div_zero)
            fast_result = op[1] ? dividend : 32'hFFFF_FFFF;
        else
            fast_result = op[1] ? 32'd0 : 32'h8000_0000;
    end

    // The 33rd bit of the trial subtraction is the borrow: set means "does not fit, restore".
    assign trial    = {rem_q, quo_q[31]} - {1'b0, dvs_mag};
    assign step_rem = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
    assign step_quo = {quo_q[30:0], ~trial[32]};

    always_comb begin
        final_result = 32'd0;
        if (op_rem)
            final_result = neg_rem ? (32'd0 - step_rem) : step_rem;
        else
            final_result = neg_quo ? (32'd0 - step_quo) : step_quo;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = fast ? DONE : RUN;
            RUN: begin
                if (flush)
                    state_next = IDLE;
                else if (count == 6'd31)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign stall = ~rst & (((state == IDLE) & start & ~flush) | (state == RUN));
    assign valid = (state == DONE) & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= 6'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_mag <= 32'd0;
            op_rem  <= 1'b0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            result  <= 32'd0;
        end else if (state == IDLE && accept) begin
            op_rem <= op[1];
            if (fast) begin
                result <= fast_result;
            end else begin
                rem_q   <= 32'd0;
                quo_q   <= dvd_abs;
                dvs_mag <= dvs_abs;
                count   <= 6'd0;
                neg_quo <= signed_op & (dividend[31] ^ divisor[31]);
                neg_rem <= signed_op & dividend[31];
            end
        end else if (state == RUN && !flush) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            count <= count + 6'd1;
            if (count == 6'd31)
                result <= final_result;
        end
    end

endmodule

// File: doc/ex_div_unit.md
# ex_div_unit

Iterative RV32M divider in the execute stage. It consumes DIV, DIVU, REM and REMU operands read from the ID/EX pipeline register and produces the 32-bit result for the EX/MEM register. It stalls the front of the pipeline while a division is in flight. Zero-divisor and signed-overflow cases bypass the iteration and complete in one cycle.

## Interface

- No parameters; the datapath is fixed at 32 bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  EX holds a divide-class instruction; level, held by the stalled ID/EX register.
- op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  in  32  rs1 value, after forwarding.
- divisor  in  32  rs2 value, after forwarding.
- flush  in  1  kill the in-flight operation (branch/jump redirect).
- stall  out  1  hold PC, IF/ID and ID/EX; combinational from state and start.
- valid  out  1  result is valid in this cycle.
- result  out  32  quotient or remainder, registered.

## Operation

- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with flush=0 latches operands and op.
  - Fast case (divisor==0, or signed op with dividend==0x80000000 and divisor==0xFFFFFFFF): load result and go to DONE.
  - Otherwise: load magnitudes, clear the 6-bit counter, go to RUN.
- Signed ops (DIV, REM):
  - Operands are converted to absolute values.
  - Quotient sign = dividend[31] XOR divisor[31].
  - Remainder sign = dividend[31].
- Unsigned ops: operands are used as-is.
- RUN: one restoring step per cycle.
  - Shift the {remainder,quotient} pair left by 1.
  - Trial-subtract the divisor magnitude using a 33-bit subtract.
  - If the result is non-negative, keep it and set quotient bit 0.
  - After the 32nd step (counter==31), apply sign correction, write result, go to DONE.
- DONE: valid=1 for exactly one cycle, then go to IDLE unconditionally.
- Special results:
  - Divide by zero: quotient 0xFFFFFFFF; remainder = dividend (unmodified).
  - Signed overflow: quotient 0x80000000; remainder 0.
- start is ignored outside IDLE; the next acceptance needs IDLE again.
- stall = ~rst & ((state==IDLE & start & ~flush) | state==RUN). It is low in DONE so the pipeline advances and captures result.
- flush:
  - In RUN or DONE: next state IDLE; valid is suppressed in that cycle; result keeps its old value.
  - In IDLE: start is ignored (flush wins over a simultaneous start).
- result holds its value until overwritten by the next completed operation.

## Timing

- C0 is the cycle in which start is seen in IDLE.
- Normal path:
  - stall high C0..C32.
  - RUN during C1..C32.
  - DONE, valid=1, result valid in C33.
  - Latency 33 cycles.
- Fast path:
  - stall high in C0 only.
  - DONE with valid=1 in C1.
  - Latency 1 cycle.
- Back-to-back: a new start may be accepted in the cycle after DONE; there are no dead cycles beyond IDLE.
- Reset values: state IDLE, counter 0, result 0x00000000, valid 0, stall 0.
- Reset asserted mid-RUN: IDLE immediately; stall and valid drop asynchronously.
- Operand inputs may change after C0 without effect; the latched copies are used.

## Test plan

- DIVU 100/7 -> stall high 33 cycles (C0..C32); in C33 valid=1, result=14. Repeat with REMU -> result=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> result 0xFFFFFFFD (-3). REM with the same operands -> result 0xFFFFFFFF (-1). DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
- DIV 5/0 -> 0xFFFFFFFF in C1; REMU 5/0 -> 5 in C1; stall high in C0 only.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in C1; REM with the same operands -> 0 in C1.
- flush asserted in C10 of a DIVU -> IDLE at next edge, stall low, no valid pulse, result unchanged. Then start DIVU 9/3 -> 3 after 33 cycles.
- rst pulsed in C15 -> stall, valid and result go to 0 immediately. Two back-to-back DIVU (20/4, then 21/4) -> valid in C33 with 5 and in C67 with 5; REMU 21/4 -> 1.
